// File: rtl/add_serial_pkg.sv
// Shared types for the chunk-serial adder.
package add_serial_pkg;

`include "add_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE = `ADD_ST_IDLE,
    ST_CALC = `ADD_ST_CALC,
    ST_DONE = `ADD_ST_DONE
  } state_t;

endpackage

// File: rtl/add_defs.vh
// State encodings for the add_serial control FSM, shared by the package and anything else that needs them.
`ifndef ADD_DEFS_VH
`define ADD_DEFS_VH

`define ADD_ST_IDLE 2'd0
`define ADD_ST_CALC 2'd1
`define ADD_ST_DONE 2'd2

`endif

// File: rtl/addc.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into the MSB for overflow detection.
module addc #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[W];
  assign cmsb = c[W-1];

endmodule

// File: rtl/add_serial.sv
// Chunk-serial adder/subtractor: one CHUNK-bit slice per clock, LSB first, valid/ready on both sides.
module add_serial
  import add_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              carry_reg, cout_reg, ovf_reg;
  logic [CW-1:0]     cnt_reg;

  logic [CHUNK-1:0]  a_chunk, b_chunk, chunk_sum;
  logic              chunk_cout, chunk_cmsb;
  logic              last_chunk;

  assign a_chunk    = a_reg[cnt_reg*CHUNK +: CHUNK];
  assign b_chunk    = b_reg[cnt_reg*CHUNK +: CHUNK];
  assign last_chunk = (cnt_reg == LAST);

  addc #(.W(CHUNK)) u_addc (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_reg),
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .cmsb (chunk_cmsb)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid)   state_next = ST_CALC;
      ST_CALC: if (last_chunk) state_next = ST_DONE;
      ST_DONE: if (out_ready)  state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          // Subtraction is folded into addition: A + ~B + 1.
          if (in_valid) begin
            a_reg     <= A;
            b_reg     <= sub ? ~B : B;
            carry_reg <= sub ? 1'b1 : Cin;
            cnt_reg   <= '0;
          end
        end
        ST_CALC: begin
          sum_reg[cnt_reg*CHUNK +: CHUNK] <= chunk_sum;
          carry_reg <= chunk_cout;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_chunk) begin
            cout_reg <= chunk_cout;
            ovf_reg  <= chunk_cmsb ^ chunk_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign Sum       = sum_reg;
  assign Cout      = cout_reg;
  assign Ovf       = ovf_reg;

endmodule

// File: tb/tb_add_serial.sv
// Scoreboard bench for add_serial: driver pushes model results, a negedge monitor pops them on each output handshake.
module tb_add_serial;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int NCH   = WIDTH / CHUNK;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Sum;
  logic        Cout;
  logic        Ovf;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  add_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic s);
    exp_t m;
    int sa, sb, r, u;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      m.sum  = a - b;
      m.cout = (a >= b);
      r      = sa - sb;
    end else begin
      u      = int'(a) + int'(b) + int'(cin);
      m.sum  = u[15:0];
      m.cout = (u > 65535);
      r      = sa + sb + int'(cin);
    end
    m.ovf = (r > 32767) || (r < -32768);
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic s, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    e = model(a, b, cin, s);
    A = a; B = b; Cin = cin; sub = s; in_valid = 1'b1;
    exp_q.push_back(e);
    step();
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    check("latency", n, NCH);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      A = 16'($urandom); B = 16'($urandom);
      step();
      check("hold_sum", {16'd0, Sum}, {16'd0, e.sum});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_after_ack", {31'd0, in_ready}, 32'd1);
    check("valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sum", {16'd0, Sum}, {16'd0, e.sum});
          check("cout", {31'd0, Cout}, {31'd0, e.cout});
          check("ovf", {31'd0, Ovf}, {31'd0, e.ovf});
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    repeat (3) step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, Sum}, 32'd0);
    check("rst_cout", {31'd0, Cout}, 32'd0);
    check("rst_ovf", {31'd0, Ovf}, 32'd0);
    rst = 1'b0;
    step();

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 3);
    send(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 2);
    send(16'h1234, 16'h1234, 1'b0, 1'b1, 0);

    // Abort in the second CALC cycle.
    A = 16'h1234; B = 16'h1111; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_calc_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_calc_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_calc_sum", {16'd0, Sum}, 32'd0);
    check("abort_calc_cout", {31'd0, Cout}, 32'd0);
    check("abort_calc_ovf", {31'd0, Ovf}, 32'd0);
    repeat (6) step();
    check("abort_calc_no_result", {31'd0, out_valid}, 32'd0);

    // Abort in DONE while the consumer is ready in the same cycle.
    A = 16'hFFFF; B = 16'h0003; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (NCH) step();
    check("abort_done_reached", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    check("abort_done_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_done_sum", {16'd0, Sum}, 32'd0);
    check("abort_done_cout", {31'd0, Cout}, 32'd0);
    step();

    for (int i = 0; i < 1000; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    repeat (3) step();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
